// File: rtl/mips_hazard_ctrl.sv
// Hazard and pipeline-control unit for a 5-stage MIPS pipeline.
// Detects RAW hazards in ID, sequences taken-branch flushes, drains the
// pipe on HALT and counts data-hazard stall cycles.
module mips_hazard_ctrl #(
    parameter int FWD_EN     = 0,
    parameter int BR_PENALTY = 2,
    parameter int DRAIN_CYC  = 3
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_wr_en,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        mem_wr_en,
    input  logic [4:0]  mem_rd,
    input  logic        wb_wr_en,
    input  logic [4:0]  wb_rd,
    input  logic        branch_taken,
    input  logic        halt_dec,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        halted,
    output logic        stall_active,
    output logic [15:0] stall_cnt,
    output logic [1:0]  ctrl_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int              DW         = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [2:0]      FLUSH_LOAD = 3'(BR_PENALTY - 1);
    localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYC);
    localparam bit              BR_MULTI   = (BR_PENALTY > 1);

    // A writer matches a source only when enabled and not targeting R0.
    function automatic logic reg_match(input logic [4:0] r, input logic en, input logic [4:0] rd);
        return en & (rd == r) & (r != 5'd0);
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      flush_cnt_q, flush_cnt_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;
    logic            haz_s;
    logic            pc_hold_s, ifid_hold_s, ifid_flush_s, idex_bubble_s;
    logic            halted_s, stall_active_s;

    // Hazard detection: full RAW check without forwarding, load-use only with it.
    always_comb begin
        haz_s = 1'b0;
        if (FWD_EN != 0) begin
            haz_s = id_valid &
                    ((id_uses_rs & reg_match(id_rs, ex_wr_en & ex_is_load, ex_rd)) |
                     (id_uses_rt & reg_match(id_rt, ex_wr_en & ex_is_load, ex_rd)));
        end else begin
            haz_s = id_valid &
                    ((id_uses_rs & (reg_match(id_rs, ex_wr_en, ex_rd) |
                                    reg_match(id_rs, mem_wr_en, mem_rd) |
                                    reg_match(id_rs, wb_wr_en, wb_rd))) |
                     (id_uses_rt & (reg_match(id_rt, ex_wr_en, ex_rd) |
                                    reg_match(id_rt, mem_wr_en, mem_rd) |
                                    reg_match(id_rt, wb_wr_en, wb_rd))));
        end
    end

    // Control FSM next-state and raw pipeline controls (branch > hazard > halt).
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        pc_hold_s      = 1'b0;
        ifid_hold_s    = 1'b0;
        ifid_flush_s   = 1'b0;
        idex_bubble_s  = 1'b0;
        halted_s       = 1'b0;
        stall_active_s = 1'b0;
        case (state_q)
            ST_RUN, ST_FLUSH, ST_DRAIN: begin
                if (branch_taken) begin
                    // Taken branch (also cancels a wrong-path drain).
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                    drain_cnt_d   = '0;
                    if (BR_MULTI) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d     = ST_RUN;
                        flush_cnt_d = 3'd0;
                    end
                end else if (state_q == ST_FLUSH) begin
                    ifid_flush_s = 1'b1;
                    if (flush_cnt_q <= 3'd1) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = 3'd0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end else if (state_q == ST_DRAIN) begin
                    pc_hold_s     = 1'b1;
                    ifid_hold_s   = 1'b1;
                    idex_bubble_s = 1'b1;
                    if (drain_cnt_q <= DW'(1)) begin
                        state_d     = ST_HALT;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DW'(1);
                    end
                end else if (haz_s) begin
                    pc_hold_s      = 1'b1;
                    ifid_hold_s    = 1'b1;
                    idex_bubble_s  = 1'b1;
                    stall_active_s = 1'b1;
                end else if (id_valid & halt_dec) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                halted_s      = 1'b1;
                pc_hold_s     = 1'b1;
                ifid_hold_s   = 1'b1;
                idex_bubble_s = 1'b1;
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = 3'd0;
                drain_cnt_d = '0;
            end
        endcase
    end

    // Stall counter: counts only data-hazard stall cycles, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_active_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
            drain_cnt_q <= '0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Controls must react in the same cycle, and reset must force them low
    // even while hazard inputs are active.
    assign pc_hold      = pc_hold_s      & ~rst;
    assign ifid_hold    = ifid_hold_s    & ~rst;
    assign ifid_flush   = ifid_flush_s   & ~rst;
    assign idex_bubble  = idex_bubble_s  & ~rst;
    assign halted       = halted_s       & ~rst;
    assign stall_active = stall_active_s & ~rst;
    assign stall_cnt    = stall_cnt_q;
    assign ctrl_state   = rst ? 2'd0 : state_q;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed self-checking bench: one DUT without forwarding, one with.
module tb_mips_hazard_ctrl;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        iv0, iv1;
    logic        id_uses_rs, id_uses_rt;
    logic [4:0]  id_rs, id_rt;
    logic        ex_wr_en, ex_is_load;
    logic [4:0]  ex_rd;
    logic        mem_wr_en, wb_wr_en;
    logic [4:0]  mem_rd, wb_rd;
    logic        branch_taken, halt_dec;

    logic        pc_hold0, ifid_hold0, ifid_flush0, idex_bubble0, halted0, stall_active0;
    logic [15:0] stall_cnt0;
    logic [1:0]  ctrl_state0;
    logic        pc_hold1, ifid_hold1, ifid_flush1, idex_bubble1, halted1, stall_active1;
    logic [15:0] stall_cnt1;
    logic [1:0]  ctrl_state1;

    int total = 0;
    int bad   = 0;

    always #5 clk1 = ~clk1;

    mips_hazard_ctrl #(.FWD_EN(0), .BR_PENALTY(2), .DRAIN_CYC(3)) u_dut0 (
        .clk1(clk1), .rst(rst), .id_valid(iv0), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs(id_rs), .id_rt(id_rt), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
        .branch_taken(branch_taken), .halt_dec(halt_dec),
        .pc_hold(pc_hold0), .ifid_hold(ifid_hold0), .ifid_flush(ifid_flush0),
        .idex_bubble(idex_bubble0), .halted(halted0), .stall_active(stall_active0),
        .stall_cnt(stall_cnt0), .ctrl_state(ctrl_state0)
    );

    mips_hazard_ctrl #(.FWD_EN(1), .BR_PENALTY(2), .DRAIN_CYC(3)) u_dut1 (
        .clk1(clk1), .rst(rst), .id_valid(iv1), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs(id_rs), .id_rt(id_rt), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
        .branch_taken(branch_taken), .halt_dec(halt_dec),
        .pc_hold(pc_hold1), .ifid_hold(ifid_hold1), .ifid_flush(ifid_flush1),
        .idex_bubble(idex_bubble1), .halted(halted1), .stall_active(stall_active1),
        .stall_cnt(stall_cnt1), .ctrl_state(ctrl_state1)
    );

    // Count one comparison and report it if it differs.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk1);
        #2;
    endtask

    // Safety net in case the run ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; iv0 = 1'b1; iv1 = 1'b0;
        id_uses_rs = 1'b1; id_uses_rt = 1'b0; id_rs = 5'd3; id_rt = 5'd0;
        ex_wr_en = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd3;
        mem_wr_en = 1'b0; mem_rd = 5'd0; wb_wr_en = 1'b0; wb_rd = 5'd0;
        branch_taken = 1'b0; halt_dec = 1'b0;

        // Reset forces everything low even with a live hazard on the inputs.
        #3;
        check_val("rst_pc_hold", {31'd0, pc_hold0}, 32'd0);
        check_val("rst_bubble", {31'd0, idex_bubble0}, 32'd0);
        check_val("rst_stall_act", {31'd0, stall_active0}, 32'd0);
        check_val("rst_state", {30'd0, ctrl_state0}, 32'd0);
        tick();
        check_val("rst_stall_cnt", {16'd0, stall_cnt0}, 32'd0);
        rst = 1'b0;

        // No-forwarding RAW on rs=3 as the producer walks EX -> MEM -> WB.
        iv1 = 1'b1;
        #1;
        check_val("raw_ex_pc_hold", {31'd0, pc_hold0}, 32'd1);
        check_val("raw_ex_ifid_hold", {31'd0, ifid_hold0}, 32'd1);
        check_val("raw_ex_bubble", {31'd0, idex_bubble0}, 32'd1);
        check_val("raw_ex_stall_act", {31'd0, stall_active0}, 32'd1);
        check_val("fwd_alu_no_stall", {31'd0, pc_hold1}, 32'd0);
        tick();
        ex_wr_en = 1'b0; mem_wr_en = 1'b1; mem_rd = 5'd3;
        #1;
        check_val("raw_mem_pc_hold", {31'd0, pc_hold0}, 32'd1);
        check_val("raw_cnt1", {16'd0, stall_cnt0}, 32'd1);
        tick();
        mem_wr_en = 1'b0; wb_wr_en = 1'b1; wb_rd = 5'd3;
        #1;
        check_val("raw_wb_bubble", {31'd0, idex_bubble0}, 32'd1);
        tick();
        wb_wr_en = 1'b0;
        #1;
        check_val("raw_release", {31'd0, pc_hold0}, 32'd0);
        check_val("raw_cnt3", {16'd0, stall_cnt0}, 32'd3);
        check_val("fwd_alu_cnt0", {16'd0, stall_cnt1}, 32'd0);

        // R0 never hazards; an unused source never hazards.
        id_rs = 5'd0; ex_wr_en = 1'b1; ex_rd = 5'd0;
        #1;
        check_val("r0_no_stall", {31'd0, pc_hold0}, 32'd0);
        tick();
        check_val("r0_cnt_same", {16'd0, stall_cnt0}, 32'd3);
        id_uses_rs = 1'b0; id_rs = 5'd5; ex_rd = 5'd5;
        #1;
        check_val("unused_rs", {31'd0, pc_hold0}, 32'd0);
        ex_wr_en = 1'b0; id_rs = 5'd0;

        // Forwarding: load-use on rt=7 costs exactly one bubble.
        iv0 = 1'b0; iv1 = 1'b1; id_uses_rt = 1'b1; id_rt = 5'd7;
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
        #1;
        check_val("lu_bubble", {31'd0, idex_bubble1}, 32'd1);
        check_val("lu_nofwd_off", {31'd0, pc_hold0}, 32'd0);
        tick();
        ex_wr_en = 1'b0; ex_is_load = 1'b0; mem_wr_en = 1'b1; mem_rd = 5'd7;
        #1;
        check_val("lu_mem_no_bubble", {31'd0, idex_bubble1}, 32'd0);
        check_val("lu_cnt1", {16'd0, stall_cnt1}, 32'd1);
        tick();
        mem_wr_en = 1'b0; ex_wr_en = 1'b1; ex_rd = 5'd7;
        #1;
        check_val("alu_fwd_no_bubble", {31'd0, idex_bubble1}, 32'd0);
        tick();
        check_val("alu_fwd_cnt1", {16'd0, stall_cnt1}, 32'd1);
        ex_wr_en = 1'b0; id_uses_rt = 1'b0; id_rt = 5'd0; iv1 = 1'b0;

        // Branch wins over a concurrent hazard; one extra flush cycle.
        iv0 = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd3; ex_wr_en = 1'b1; ex_rd = 5'd3;
        branch_taken = 1'b1;
        #1;
        check_val("br_n_flush", {31'd0, ifid_flush0}, 32'd1);
        check_val("br_n_bubble", {31'd0, idex_bubble0}, 32'd1);
        check_val("br_n_pc_hold", {31'd0, pc_hold0}, 32'd0);
        check_val("br_n_stall_act", {31'd0, stall_active0}, 32'd0);
        tick();
        branch_taken = 1'b0;
        #1;
        check_val("br_n1_state", {30'd0, ctrl_state0}, 32'd1);
        check_val("br_n1_flush", {31'd0, ifid_flush0}, 32'd1);
        check_val("br_n1_pc_hold", {31'd0, pc_hold0}, 32'd0);
        tick();
        #1;
        check_val("br_n2_state", {30'd0, ctrl_state0}, 32'd0);
        check_val("br_n2_flush", {31'd0, ifid_flush0}, 32'd0);
        check_val("br_cnt_same", {16'd0, stall_cnt0}, 32'd3);
        ex_wr_en = 1'b0; id_uses_rs = 1'b0; id_rs = 5'd0;

        // HALT: three drain cycles, then sticky halted ignoring inputs.
        halt_dec = 1'b1;
        #1;
        check_val("halt_dec_state", {30'd0, ctrl_state0}, 32'd0);
        tick();
        halt_dec = 1'b0; iv0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("drain_state", {30'd0, ctrl_state0}, 32'd2);
            check_val("drain_hold", {31'd0, pc_hold0}, 32'd1);
            check_val("drain_bubble", {31'd0, idex_bubble0}, 32'd1);
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            if (i == 4) begin
                branch_taken = 1'b1; iv0 = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd3;
                ex_wr_en = 1'b1; ex_rd = 5'd3;
            end else begin
                branch_taken = 1'b0; iv0 = 1'b0; ex_wr_en = 1'b0;
            end
            #1;
            check_val("halt_halted", {31'd0, halted0}, 32'd1);
            check_val("halt_state", {30'd0, ctrl_state0}, 32'd3);
            check_val("halt_flush", {31'd0, ifid_flush0}, 32'd0);
            tick();
        end
        branch_taken = 1'b0; iv0 = 1'b0; ex_wr_en = 1'b0; id_uses_rs = 1'b0; id_rs = 5'd0;
        check_val("halt_cnt_same", {16'd0, stall_cnt0}, 32'd3);

        // Reset clears HALT; then one stall so the counter is nonzero.
        rst = 1'b1;
        #1;
        check_val("unhalt_rst", {31'd0, halted0}, 32'd0);
        rst = 1'b0;
        tick();
        iv0 = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd3; ex_wr_en = 1'b1; ex_rd = 5'd3;
        tick();
        ex_wr_en = 1'b0; id_uses_rs = 1'b0; id_rs = 5'd0;
        #1;
        check_val("post_rst_cnt1", {16'd0, stall_cnt0}, 32'd1);

        // Branch in first drain cycle cancels the HALT.
        halt_dec = 1'b1;
        tick();
        halt_dec = 1'b0; iv0 = 1'b0; branch_taken = 1'b1;
        #1;
        check_val("cancel_state_drain", {30'd0, ctrl_state0}, 32'd2);
        check_val("cancel_flush", {31'd0, ifid_flush0}, 32'd1);
        check_val("cancel_bubble", {31'd0, idex_bubble0}, 32'd1);
        check_val("cancel_pc_hold", {31'd0, pc_hold0}, 32'd0);
        tick();
        branch_taken = 1'b0;
        #1;
        check_val("cancel_state_flush", {30'd0, ctrl_state0}, 32'd1);
        check_val("cancel_halted_a", {31'd0, halted0}, 32'd0);
        tick();
        #1;
        check_val("cancel_state_run", {30'd0, ctrl_state0}, 32'd0);
        tick();
        tick();
        check_val("cancel_halted_b", {31'd0, halted0}, 32'd0);

        // Asynchronous reset in the middle of a drain.
        iv0 = 1'b1; halt_dec = 1'b1;
        tick();
        halt_dec = 1'b0; iv0 = 1'b0;
        #1;
        check_val("mid_drain_state", {30'd0, ctrl_state0}, 32'd2);
        tick();
        rst = 1'b1;
        #1;
        check_val("arst_pc_hold", {31'd0, pc_hold0}, 32'd0);
        check_val("arst_ifid_hold", {31'd0, ifid_hold0}, 32'd0);
        check_val("arst_bubble", {31'd0, idex_bubble0}, 32'd0);
        check_val("arst_state", {30'd0, ctrl_state0}, 32'd0);
        check_val("arst_cnt", {16'd0, stall_cnt0}, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        #1;
        check_val("arst_resume_run", {30'd0, ctrl_state0}, 32'd0);
        check_val("arst_resume_hold", {31'd0, pc_hold0}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check_val("arst_no_halt", {31'd0, halted0}, 32'd0);
        check_val("arst_still_run", {30'd0, ctrl_state0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
